// File: rtl/l1_cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped L1 data cache.
package l1_cache_pkg;

  localparam int unsigned ADDR_W     = 15;
  localparam int unsigned BLOCK_SIZE = 4;
  localparam int unsigned NUM_BLOCKS = 64;
  localparam int unsigned OFFSET_W   = $clog2(BLOCK_SIZE);
  localparam int unsigned INDEX_W    = $clog2(NUM_BLOCKS);
  localparam int unsigned TAG_W      = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StRefill,
    StL2Wait,
    StWriteFwd,
    StRespond
  } state_e;

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

endpackage

// File: rtl/l1_l2_port.sv
// L2 request port: registered L2 requests, busy falling-edge counting, post-read guard cycles.
module l1_l2_port
  import l1_cache_pkg::*;
#(
  parameter int unsigned n = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_read,
  input  logic              start_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [n-1:0]      req_wdata,
  output logic              idle,
  output logic              done,
  output logic [n-1:0]      rdata,
  output logic [ADDR_W-1:0] L2_word_address,
  output logic [n-1:0]      L2_wdata,
  output logic              L2_read_request,
  output logic              L2_write_request,
  input  logic [n-1:0]      L2_rdata,
  input  logic              L2_busy
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [n-1:0]      wdata_q, wdata_d;
  logic              rreq_q, rreq_d;
  logic              wreq_q, wreq_d;
  logic              busy_prev_q;
  logic [1:0]        fall_cnt_q, fall_cnt_d;
  logic [1:0]        guard_q, guard_d;
  logic              fall, read_done, write_done;

  assign fall       = busy_prev_q & ~L2_busy;
  // Read data is valid in the cycle after the first fall while busy stays low.
  assign read_done  = rreq_q & ~L2_busy & (fall_cnt_q != 2'd0);
  assign write_done = wreq_q & fall & (fall_cnt_q != 2'd0);
  assign done       = read_done | write_done;
  assign idle       = ~rreq_q & ~wreq_q & (guard_q == 2'd0);
  assign rdata      = L2_rdata;

  assign L2_word_address  = addr_q;
  assign L2_wdata         = wdata_q;
  assign L2_read_request  = rreq_q;
  assign L2_write_request = wreq_q;

  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rreq_d     = rreq_q;
    wreq_d     = wreq_q;
    fall_cnt_d = (fall && fall_cnt_q != 2'd3) ? fall_cnt_q + 2'd1 : fall_cnt_q;
    guard_d    = (guard_q != 2'd0) ? guard_q - 2'd1 : guard_q;
    if (start_read) begin
      rreq_d     = 1'b1;
      addr_d     = req_addr;
      fall_cnt_d = 2'd0;
    end
    if (start_write) begin
      wreq_d     = 1'b1;
      addr_d     = req_addr;
      wdata_d    = req_wdata;
      fall_cnt_d = 2'd0;
    end
    if (read_done) begin
      rreq_d  = 1'b0;
      guard_d = 2'd2;
    end
    if (write_done) begin
      wreq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      rreq_q      <= 1'b0;
      wreq_q      <= 1'b0;
      busy_prev_q <= 1'b0;
      fall_cnt_q  <= 2'd0;
      guard_q     <= 2'd0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rreq_q      <= rreq_d;
      wreq_q      <= wreq_d;
      busy_prev_q <= L2_busy;
      fall_cnt_q  <= fall_cnt_d;
      guard_q     <= guard_d;
    end
  end

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped write-through, no-write-allocate L1 data cache in front of the L2.
// Define L1_STATS_EN to build the hit/miss statistics counters.
module l1_cache
  import l1_cache_pkg::*;
#(
  parameter int unsigned n          = 32,
  parameter int unsigned block_size = BLOCK_SIZE,
  parameter int unsigned num_blocks = NUM_BLOCKS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_word_address,
  input  logic [n-1:0]      cpu_wdata,
  input  logic              cpu_read_request,
  input  logic              cpu_write_request,
  output logic [n-1:0]      cpu_rdata,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] L2_word_address,
  output logic [n-1:0]      L2_wdata,
  output logic              L2_read_request,
  output logic              L2_write_request,
  input  logic [n-1:0]      L2_rdata,
  input  logic              L2_busy,
  output logic [31:0]       L1_statistics
);

  localparam int unsigned MemIdxW = INDEX_W + OFFSET_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [n-1:0]      wdata_q, wdata_d;
  logic              is_write_q, is_write_d;
  logic [OFFSET_W-1:0] k_q, k_d;
  logic [n-1:0]      cpu_rdata_q, cpu_rdata_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic [num_blocks-1:0] valid_q, valid_d;

  logic [n-1:0]     data_mem [block_size*num_blocks];
  logic [TAG_W-1:0] tag_mem  [num_blocks];

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic [OFFSET_W-1:0] off;
  logic                hit;
  logic                mem_we, tag_we;
  logic [MemIdxW-1:0]  mem_widx;
  logic [n-1:0]        mem_wdata;
  logic                start_read, start_write, port_idle, port_done;
  logic [n-1:0]        port_rdata;
  logic [ADDR_W-1:0]   port_addr;

  assign idx = addr_index(addr_q);
  assign tag = addr_tag(addr_q);
  assign off = addr_offset(addr_q);
  assign hit = valid_q[idx] && (tag_mem[idx] == tag);

  assign port_addr = is_write_q ? addr_q : {addr_q[ADDR_W-1:OFFSET_W], k_q};
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_write_d  = is_write_q;
    k_d         = k_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ready_d = 1'b0;
    valid_d     = valid_q;
    mem_we      = 1'b0;
    mem_widx    = {idx, off};
    mem_wdata   = wdata_q;
    tag_we      = 1'b0;
    start_read  = 1'b0;
    start_write = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cpu_read_request || cpu_write_request) begin
          addr_d     = cpu_word_address;
          wdata_d    = cpu_wdata;
          is_write_d = cpu_write_request;
          state_d    = StLookup;
        end
      end
      StLookup: begin
        if (is_write_q) begin
          mem_we  = hit;
          state_d = StWriteFwd;
        end else if (hit) begin
          cpu_rdata_d = data_mem[{idx, off}];
          cpu_ready_d = 1'b1;
          state_d     = StRespond;
        end else begin
          k_d     = '0;
          state_d = StRefill;
        end
      end
      StRefill: begin
        if (port_idle) begin
          start_read = 1'b1;
          state_d    = StL2Wait;
        end
      end
      StWriteFwd: begin
        if (port_idle) begin
          start_write = 1'b1;
          state_d     = StL2Wait;
        end
      end
      StL2Wait: begin
        if (port_done) begin
          if (is_write_q) begin
            cpu_ready_d = 1'b1;
            state_d     = StRespond;
          end else begin
            mem_we    = 1'b1;
            mem_widx  = {idx, k_q};
            mem_wdata = port_rdata;
            k_d       = k_q + OFFSET_W'(1);
            if (k_q == OFFSET_W'(block_size - 1)) begin
              tag_we       = 1'b1;
              valid_d[idx] = 1'b1;
              // Requested word may be the one arriving this cycle.
              cpu_rdata_d  = (k_q == off) ? port_rdata : data_mem[{idx, off}];
              cpu_ready_d  = 1'b1;
              state_d      = StRespond;
            end else begin
              state_d = StRefill;
            end
          end
        end
      end
      StRespond: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_write_q  <= 1'b0;
      k_q         <= '0;
      cpu_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_write_q  <= is_write_d;
      k_q         <= k_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      valid_q     <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) data_mem[mem_widx] <= mem_wdata;
    if (tag_we) tag_mem[idx] <= tag;
  end

`ifdef L1_STATS_EN
  logic [7:0] read_hit_q, read_miss_q, write_hit_q, write_miss_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_hit_q   <= 8'd0;
      read_miss_q  <= 8'd0;
      write_hit_q  <= 8'd0;
      write_miss_q <= 8'd0;
    end else if (state_q == StLookup) begin
      if (is_write_q && hit)       write_hit_q  <= write_hit_q + 8'd1;
      else if (is_write_q)         write_miss_q <= write_miss_q + 8'd1;
      else if (hit)                read_hit_q   <= read_hit_q + 8'd1;
      else                         read_miss_q  <= read_miss_q + 8'd1;
    end
  end

  assign L1_statistics = {read_hit_q, read_miss_q, write_hit_q, write_miss_q};
`else
  assign L1_statistics = '0;
`endif

  l1_l2_port #(
    .n(n)
  ) u_port (
    .clk              (clk),
    .reset            (reset),
    .start_read       (start_read),
    .start_write      (start_write),
    .req_addr         (port_addr),
    .req_wdata        (wdata_q),
    .idle             (port_idle),
    .done             (port_done),
    .rdata            (port_rdata),
    .L2_word_address  (L2_word_address),
    .L2_wdata         (L2_wdata),
    .L2_read_request  (L2_read_request),
    .L2_write_request (L2_write_request),
    .L2_rdata         (L2_rdata),
    .L2_busy          (L2_busy)
  );

endmodule
